mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Multi-cycle signed multiply/divide unit for the Mini-SRC datapath.
- Sits directly upstream of the HI and LO general-purpose registers. Its result_hi/result_lo outputs drive their D inputs; done drives their enables.
- Operands come from the register-file read bus. One operation is in flight at a time, with a start/done handshake toward the control unit.
- Multiply uses radix-2 Booth. Divide uses restoring division on magnitudes with a sign fixup.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH split into hi/lo.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  request a new operation; honoured only in IDLE.
- op  input  1  0 = signed multiply, 1 = signed divide.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid and just updated.
- result_hi  output  WIDTH  product[63:32], or division remainder.
- result_lo  output  WIDTH  product[31:0], or division quotient.
- div_by_zero  output  1  set with done when op=1 and b=0; held until the next done.

Behaviour:
- Reset (clr=0 at an edge):
  - State goes to IDLE.
  - busy, done, div_by_zero, result_hi and result_lo all go to 0.
  - Internal accumulators and the counter are cleared.
  - An operation in progress is aborted and no done is produced.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE:
  - At an edge with start=1, latch a, b and op, clear the counter, and go to MUL (op=0) or DIV (op=1).
  - For divide, also latch the operand signs and the magnitudes |a| and |b|.
  - With start=0, stay in IDLE.
- MUL: one Booth step per edge on a {A[WIDTH], Q[WIDTH], q-1} register.
  - Add b, subtract b, or do nothing, chosen by (Q[0], q-1).
  - Then arithmetic-shift-right by 1.
  - The counter increments each edge. After the ITER-th step, go to FIXUP.
- DIV: one restoring step per edge.
  - Shift the {R, Q} pair left, then trial-subtract |b| from R.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore R and set the quotient bit to 0.
  - After ITER steps, go to FIXUP.
- FIXUP (one edge):
  - Load result_hi and result_lo, assert done for the following cycle, and go to DONE.
  - Multiply: hi = A, lo = Q.
  - Divide: quotient is negated if sign(a) XOR sign(b); remainder is negated if sign(a). Quotient truncates toward zero and the remainder takes the dividend's sign.
  - Divide by zero (b==0): hi = a, lo = all ones, div_by_zero = 1. Latency is unchanged.
  - Divide 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (natural wrap, no flag).
- DONE (one cycle): done=1, busy=0. Next edge goes to IDLE and done returns to 0.
- Latency:
  - Start is sampled at edge 0; steps run at edges 1..ITER; FIXUP is at edge ITER+1.
  - done is high for exactly one cycle after edge ITER+1 (33 for the default), for both ops.
  - busy is high after edge 0 through edge ITER+1, i.e. in MUL, DIV and FIXUP.
- Handshake and holding:
  - start is ignored in MUL, DIV, FIXUP and DONE.
  - Operand changes after the start edge have no effect.
  - result_hi, result_lo and div_by_zero hold their values until the next FIXUP or reset.
  - div_by_zero is cleared at every FIXUP that is not a divide by zero.
- Arithmetic: A is WIDTH+1 bits internally so Booth add/sub of -2^31 does not overflow. Outputs are truncated to WIDTH.

Decomposition:
- mul_div_pkg holds:
  - the state encoding (IDLE, MUL, DIV, FIXUP, DONE);
  - the op codes OP_MUL = 1'b0 and OP_DIV = 1'b1;
  - the default ITER constant.
- One sub-module, div_step: combinational restoring step.
  - Inputs: R, Q, |b|. Outputs: next R, next Q.
  - Instantiated once and reused every DIV cycle.
- Booth logic stays inline.

Test Plan:
- Multiply: op=0, a=7, b=0xFFFFFFFD (-3) -> done once, 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles before done.
- Multiply, most-negative operands: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
- Signed divide: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=100, b=7 -> lo=14, hi=2.
- Divide by zero: a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1 with done. A subsequent divide 9/3 -> lo=3, hi=0, div_by_zero=0.
- Start while busy: pulse start with new operands at cycle 10 of a multiply -> ignored; exactly one done, carrying the original result; a start in the DONE cycle is also ignored.
- Reset mid-operation: clr=0 at cycle 12 of a divide -> next cycle busy=0, done never pulses, all outputs 0; a fresh multiply 3*4 then gives lo=12, hi=0.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared definitions for the multi-cycle signed multiply/divide unit:
// controller states, operation codes and the default iteration count.
package mul_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIXUP,
        DONE
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int DEFAULT_ITER = 32;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift {rem, quo} left by one, then trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // The extra top bit keeps the shifted remainder exact before the compare.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, divisor});
        rem_next = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes with sign fixup) feeding the HI/LO registers.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = DEFAULT_ITER
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(ITER + 1);

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  count;
    logic           last_step;

    logic [WIDTH:0]   acc_a;
    logic [WIDTH-1:0] acc_q;
    logic             q_m1;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] mag_b;
    logic             op_reg;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH+1:0] a_sext;
    logic [WIDTH+1:0] b_sext;
    logic [WIDTH+1:0] booth_sum;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic             fix_dbz;

    assign last_step = (count == CW'(ITER - 1));
    assign busy      = (state == MUL) || (state == DIV) || (state == FIXUP);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (op == OP_DIV) ? DIV : MUL;
                end
            end
            MUL:     if (last_step) next_state = FIXUP;
            DIV:     if (last_step) next_state = FIXUP;
            FIXUP:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Booth add/sub is done one bit wider than A so the shifted-in sign is exact.
    always_comb begin
        a_sext = {acc_a[WIDTH], acc_a};
        b_sext = {{2{mcand[WIDTH-1]}}, mcand};
        case ({acc_q[0], q_m1})
            2'b10:   booth_sum = a_sext - b_sext;
            2'b01:   booth_sum = a_sext + b_sext;
            default: booth_sum = a_sext;
        endcase
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem      (acc_a[WIDTH-1:0]),
        .quo      (acc_q),
        .divisor  (mag_b),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        fix_hi  = acc_a[WIDTH-1:0];
        fix_lo  = acc_q;
        fix_dbz = 1'b0;
        if (op_reg == OP_DIV) begin
            if (mag_b == '0) begin
                fix_hi  = dividend;
                fix_lo  = '1;
                fix_dbz = 1'b1;
            end else begin
                fix_lo = (sign_a ^ sign_b) ? -acc_q : acc_q;
                fix_hi = sign_a ? -acc_a[WIDTH-1:0] : acc_a[WIDTH-1:0];
            end
        end
    end

    // For divide, acc_a holds the partial remainder and acc_q the dividend/quotient.
    always_ff @(posedge clk) begin
        if (!clr) begin
            count       <= '0;
            acc_a       <= '0;
            acc_q       <= '0;
            q_m1        <= 1'b0;
            mcand       <= '0;
            dividend    <= '0;
            mag_b       <= '0;
            op_reg      <= OP_MUL;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        op_reg   <= op;
                        mcand    <= b;
                        dividend <= a;
                        q_m1     <= 1'b0;
                        acc_a    <= '0;
                        if (op == OP_DIV) begin
                            sign_a <= a[WIDTH-1];
                            sign_b <= b[WIDTH-1];
                            acc_q  <= a[WIDTH-1] ? -a : a;
                            mag_b  <= b[WIDTH-1] ? -b : b;
                        end else begin
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            acc_q  <= a;
                            mag_b  <= '0;
                        end
                    end
                end
                MUL: begin
                    acc_a <= booth_sum[WIDTH+1:1];
                    acc_q <= {booth_sum[0], acc_q[WIDTH-1:1]};
                    q_m1  <= acc_q[0];
                    count <= count + CW'(1);
                end
                DIV: begin
                    acc_a <= {1'b0, rem_next};
                    acc_q <= quo_next;
                    count <= count + CW'(1);
                end
                FIXUP: begin
                    result_hi   <= fix_hi;
                    result_lo   <= fix_lo;
                    div_by_zero <= fix_dbz;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
